rb_sysbus_initiator: RTL and testbench

Bus-master end of the RadioBox system-bus register interface. Accepts read/write commands on a ready/valid stream and buffers them in a small FIFO. Issues each command as a single-cycle `sys_wen`/`sys_ren` strobe toward a system-bus slave such as the RadioBox register bank, then waits for `sys_ack` under a timeout and returns one response per command. Used by on-chip sequencers (sweep/modulation control) to program OSC increment/offset registers without the PS.

---
 rtl/rb_sysbus_initiator.sv | 151 +++++++++++++++
 tb/tb_rb_sysbus_initiator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_sysbus_initiator.sv
// rb_sysbus_initiator: system-bus master that queues read/write commands and
// issues them one at a time as single-cycle strobes, returning one response per
// command with an ack timeout.
//
// Ports:
//   clk_adc_125mhz, adc_rst_i          clock, async active-high reset
//   cmd_vld/cmd_rdy, cmd_we, cmd_addr,
//   cmd_wdata, cmd_sel                 command stream into the FIFO
//   rsp_vld/rsp_rdy, rsp_rdata,
//   rsp_err, rsp_timeout               response stream, one per command
//   sys_addr, sys_wdata, sys_sel,
//   sys_wen, sys_ren                   bus request (strobes are one cycle)
//   sys_rdata, sys_err, sys_ack        bus completion
//   busy, timeout_cnt                  status
module rb_sysbus_initiator #(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk_adc_125mhz,
    input  logic        adc_rst_i,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic [3:0]  sys_sel,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack,
    output logic        busy,
    output logic [15:0] timeout_cnt
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(CMD_DEPTH);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT, RSP, GUARD} state_t;

    state_t state, state_n;
    // FIFO entry layout: {we, sel, addr, wdata}
    logic [68:0] mem [CMD_DEPTH];
    logic [68:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_n;
    logic [7:0] wait_cnt;
    logic guard, cur_we;
    logic push, pop, ack_done, timed_out;

    assign push = cmd_vld & cmd_rdy;
    assign head = mem[rd_ptr];
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_n = state;
        pop = 1'b0;
        ack_done = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                pop = (count != '0) && !guard;
                state_n = pop ? STROBE : IDLE;
            end
            STROBE: begin
                // a combinational slave may ack during the strobe itself
                ack_done = sys_ack;
                state_n = sys_ack ? RSP : WAIT;
            end
            WAIT: begin
                // an ack on the timeout edge still completes normally
                ack_done = sys_ack;
                timed_out = !sys_ack && (wait_cnt == TO_LIM);
                state_n = (sys_ack || timed_out) ? RSP : WAIT;
            end
            RSP: state_n = rsp_rdy ? (guard ? GUARD : IDLE) : RSP;
            GUARD: state_n = sys_ack ? GUARD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_adc_125mhz or posedge adc_rst_i) begin
        if (adc_rst_i)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk_adc_125mhz) begin
        if (push)
            mem[wr_ptr] <= {cmd_we, cmd_sel, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk_adc_125mhz or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            cmd_rdy <= 1'b0;
            busy <= 1'b0;
            sys_wen <= 1'b0;
            sys_ren <= 1'b0;
            sys_addr <= '0;
            sys_wdata <= '0;
            sys_sel <= '0;
            cur_we <= 1'b0;
            wait_cnt <= '0;
            guard <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            rsp_timeout <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count_n;
            cmd_rdy <= count_n != FULL;
            busy <= (state_n != IDLE) || (count_n != '0);
            sys_wen <= pop & head[68];
            sys_ren <= pop & ~head[68];
            if (pop)
                {cur_we, sys_sel, sys_addr, sys_wdata} <= head;
            wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            rsp_vld <= state_n == RSP;
            if (ack_done) begin
                rsp_rdata <= cur_we ? 32'd0 : sys_rdata;
                rsp_err <= sys_err;
                rsp_timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_rdata <= 32'd0;
                rsp_err <= 1'b1;
                rsp_timeout <= 1'b1;
                timeout_cnt <= (timeout_cnt == 16'hFFFF) ? timeout_cnt : timeout_cnt + 16'd1;
            end
            // guard keeps a late ack of a timed-out access from completing the next one
            if (timed_out)
                guard <= 1'b1;
            else if (state == GUARD && !sys_ack)
                guard <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rb_sysbus_initiator.sv
// tb_rb_sysbus_initiator: directed bench for rb_sysbus_initiator with a registered slave model.
module tb_rb_sysbus_initiator;
    logic clk_adc_125mhz = 1'b0;
    logic adc_rst_i = 1'b1;
    logic cmd_vld = 1'b0, cmd_rdy, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0] cmd_sel = '0;
    logic rsp_vld, rsp_rdy = 1'b0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, sys_addr, sys_wdata, sys_rdata;
    logic [3:0] sys_sel;
    logic sys_wen, sys_ren, sys_err, sys_ack, busy;
    logic [15:0] timeout_cnt;

    logic slave_ack = 1'b0, slave_err = 1'b0, late_ack = 1'b0;
    logic [31:0] slave_rdata = '0;
    logic [31:0] smem [64];

    logic prev_stb = 1'b0;
    logic [3:0] last_wen_sel = '0;
    int wen_cnt = 0, ren_cnt = 0, b2b = 0;
    int pass_cnt = 0, total_cnt = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } vec_t;
    vec_t vecs[9];

    assign sys_ack = slave_ack | late_ack;
    assign sys_err = slave_err;
    assign sys_rdata = slave_rdata;

    always #5 clk_adc_125mhz = ~clk_adc_125mhz;

    rb_sysbus_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .clk_adc_125mhz(clk_adc_125mhz), .adc_rst_i(adc_rst_i),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel), .sys_wen(sys_wen),
        .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    // registered slave: acks one cycle after the strobe, errors at 0x40, never acks 0xFxxxxxxx
    always @(posedge clk_adc_125mhz) begin
        slave_ack <= 1'b0;
        slave_err <= 1'b0;
        if ((sys_wen | sys_ren) && sys_addr[31:28] != 4'hF) begin
            slave_ack <= 1'b1;
            slave_err <= sys_addr == 32'h40;
            if (sys_wen)
                smem[sys_addr[7:2]] <= sys_wdata;
            slave_rdata <= (sys_addr == 32'h40) ? 32'hDEADBEEF : smem[sys_addr[7:2]];
        end
    end

    always @(posedge clk_adc_125mhz) begin
        prev_stb <= sys_wen | sys_ren;
        if (prev_stb && (sys_wen | sys_ren))
            b2b <= b2b + 1;
        if (sys_wen) begin
            wen_cnt <= wen_cnt + 1;
            last_wen_sel <= sys_sel;
        end
        if (sys_ren)
            ren_cnt <= ren_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
        int n;
        n = 0;
        cmd_we = we;
        cmd_addr = addr;
        cmd_wdata = wdata;
        cmd_sel = sel;
        cmd_vld = 1'b1;
        while (!cmd_rdy && n < 200) begin
            @(negedge clk_adc_125mhz);
            n++;
        end
        if (!cmd_rdy) begin
            total_cnt++;
            $display("FAIL push_wait: cmd_rdy got 0 expected 1");
        end
        @(negedge clk_adc_125mhz);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_vld && n < 100) begin
            @(negedge clk_adc_125mhz);
            n++;
        end
        if (!rsp_vld) begin
            total_cnt++;
            $display("FAIL %s: rsp_vld got 0 expected 1", name);
        end
    endtask

    task automatic run_vec(input vec_t v);
        rsp_rdy = 1'b1;
        push(v.we, v.addr, v.wdata, v.sel);
        wait_rsp("vec_rsp");
        chk("vec_rdata", rsp_rdata, v.rdata);
        chk("vec_err", 32'(rsp_err), 32'(v.err));
        chk("vec_timeout", 32'(rsp_timeout), 32'(v.to));
        @(negedge clk_adc_125mhz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int n;
        logic [31:0] exp_rd [5];
        vecs[0] = '{1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h24, 32'hCAFEF00D, 4'h3, 32'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h24, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h40, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h40, 32'h1, 4'h1, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'hF0000000, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'hF0000004, 32'h5555AAAA, 4'hC, 32'h0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0};

        repeat (3) @(negedge clk_adc_125mhz);
        chk("rst_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sys_addr", sys_addr, 32'd0);
        adc_rst_i = 1'b0;
        @(negedge clk_adc_125mhz);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].we)
                chk("wen_sel", 32'(last_wen_sel), 32'(vecs[i].sel));
        end
        chk("table_timeout_cnt", 32'(timeout_cnt), 32'd2);
        chk("table_wen_cnt", wen_cnt, 4);
        chk("table_ren_cnt", ren_cnt, 5);

        // timeout latency from the strobe edge
        rsp_rdy = 1'b1;
        push(1'b0, 32'hF0000010, 32'h0, 4'hF);
        n = 0;
        while (!sys_ren && n < 20) begin
            @(negedge clk_adc_125mhz);
            n++;
        end
        chk("to_strobe_seen", 32'(sys_ren), 32'd1);
        n = 0;
        while (!rsp_vld && n < 40) begin
            @(negedge clk_adc_125mhz);
            n++;
        end
        chk("to_latency", n, 18);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_cnt", 32'(timeout_cnt), 32'd3);
        @(negedge clk_adc_125mhz);

        // back-pressure: one stalled transaction plus a full FIFO
        rsp_rdy = 1'b0;
        s = wen_cnt + ren_cnt;
        exp_rd = '{32'h0, 32'hA0A0A0A0, 32'h0, 32'h000000B1, 32'h12345678};
        push(1'b1, 32'h30, 32'hA0A0A0A0, 4'hF);
        push(1'b0, 32'h30, 32'h0, 4'hF);
        push(1'b1, 32'h34, 32'h000000B1, 4'hF);
        push(1'b0, 32'h34, 32'h0, 4'hF);
        chk("bp_rdy_before_full", 32'(cmd_rdy), 32'd1);
        push(1'b0, 32'h20, 32'h0, 4'hF);
        chk("bp_rdy_full", 32'(cmd_rdy), 32'd0);
        repeat (10) @(negedge clk_adc_125mhz);
        chk("bp_one_strobe", wen_cnt + ren_cnt, s + 1);
        chk("bp_rdy_still_full", 32'(cmd_rdy), 32'd0);
        rsp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp("bp_rsp");
            chk("bp_order_rdata", rsp_rdata, exp_rd[k]);
            @(negedge clk_adc_125mhz);
        end

        // late ack after a timeout with a second command queued
        rsp_rdy = 1'b0;
        push(1'b0, 32'hF0000020, 32'h0, 4'hF);
        push(1'b0, 32'h20, 32'h0, 4'hF);
        wait_rsp("late_to_rsp");
        chk("late_to_flag", 32'(rsp_timeout), 32'd1);
        repeat (3) @(negedge clk_adc_125mhz);
        late_ack = 1'b1;
        s = wen_cnt + ren_cnt;
        @(negedge clk_adc_125mhz);
        rsp_rdy = 1'b1;
        @(negedge clk_adc_125mhz);
        repeat (5) @(negedge clk_adc_125mhz);
        chk("late_no_strobe", wen_cnt + ren_cnt, s);
        late_ack = 1'b0;
        @(negedge clk_adc_125mhz);
        wait_rsp("late_second_rsp");
        chk("late_rdata", rsp_rdata, 32'h12345678);
        chk("late_err", 32'(rsp_err), 32'd0);
        chk("late_timeout", 32'(rsp_timeout), 32'd0);
        chk("late_one_strobe", wen_cnt + ren_cnt, s + 1);
        chk("late_to_cnt", 32'(timeout_cnt), 32'd4);
        @(negedge clk_adc_125mhz);

        // reset while waiting for an ack, with a command still queued
        rsp_rdy = 1'b1;
        push(1'b0, 32'hF0000030, 32'h0, 4'hF);
        push(1'b1, 32'h28, 32'h77777777, 4'hF);
        repeat (3) @(negedge clk_adc_125mhz);
        #2 adc_rst_i = 1'b1;
        #1;
        chk("arst_strobes", {30'd0, sys_wen, sys_ren}, 32'd0);
        chk("arst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_to_cnt", 32'(timeout_cnt), 32'd0);
        @(negedge clk_adc_125mhz);
        adc_rst_i = 1'b0;
        s = wen_cnt + ren_cnt;
        repeat (30) @(negedge clk_adc_125mhz);
        chk("arst_fifo_empty", wen_cnt + ren_cnt, s);
        chk("arst_no_rsp", 32'(rsp_vld), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);
        chk("arst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        run_vec(vecs[8]);

        chk("no_b2b_strobes", b2b, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
